// File: rtl/cp0_exc_unit_pkg.sv
// Shared CP0 constants: exception codes, CP0 register numbers and the
// packed register-field types used by the exception unit.
package cp0_exc_unit_pkg;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  typedef struct packed {
    logic [5:0] im;
    logic       exl;
    logic       ie;
  } sr_t;

  typedef struct packed {
    logic       bd;
    logic [5:0] ip;
    logic [4:0] exccode;
  } cause_t;

  localparam sr_t    SR_RESET    = '{im: 6'd0, exl: 1'b0, ie: 1'b0};
  localparam cause_t CAUSE_RESET = '{bd: 1'b0, ip: 6'd0, exccode: 5'd0};

endpackage

// File: rtl/cp0_exc_unit.sv
// Coprocessor 0 exception unit: arbitrates M-stage exceptions against external
// interrupts, holds SR/Cause/EPC/PRId and serves mfc0/mtc0/eret.
module cp0_exc_unit
  import cp0_exc_unit_pkg::*;
#(
  parameter logic [31:0] PRID       = 32'h0000_4D50,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_m,
  input  logic        bd_m,
  input  logic [4:0]  exccode_m,
  input  logic [5:0]  hwint,
  input  logic [4:0]  cp0_addr,
  input  logic        cp0_we,
  input  logic [31:0] cp0_wdata,
  input  logic        eret_m,
  output logic [31:0] cp0_rdata,
  output logic [31:0] epc_out,
  output logic        req,
  output logic [31:0] handler_pc
);

  localparam int unsigned SR_IM_LSB     = 10;
  localparam int unsigned SR_EXL_BIT    = 1;
  localparam int unsigned SR_IE_BIT     = 0;
  localparam int unsigned CAUSE_BD_BIT  = 31;
  localparam int unsigned CAUSE_IP_LSB  = 10;
  localparam int unsigned CAUSE_EXC_LSB = 2;

  function automatic logic [31:0] pack_sr(input sr_t s);
    logic [31:0] w;
    w = 32'd0;
    w[SR_IM_LSB +: 6] = s.im;
    w[SR_EXL_BIT]     = s.exl;
    w[SR_IE_BIT]      = s.ie;
    return w;
  endfunction

  function automatic logic [31:0] pack_cause(input cause_t c);
    logic [31:0] w;
    w = 32'd0;
    w[CAUSE_BD_BIT]           = c.bd;
    w[CAUSE_IP_LSB +: 6]      = c.ip;
    w[CAUSE_EXC_LSB +: 5]     = c.exccode;
    return w;
  endfunction

  sr_t         sr_q, sr_d;
  cause_t      cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic        int_pend_s;
  logic        exc_pend_s;

  // Interrupts use the live hwint lines so a newly raised line is taken with zero latency.
  always_comb begin
    int_pend_s = (|(hwint & sr_q.im)) & sr_q.ie & ~sr_q.exl;
    exc_pend_s = (exccode_m != 5'd0) & ~sr_q.exl;
    req        = (int_pend_s | exc_pend_s) & ~reset;
  end

  // Next-state: exception entry wins; otherwise mtc0 applies before the eret EXL clear.
  always_comb begin
    sr_d       = sr_q;
    cause_d    = cause_q;
    epc_d      = epc_q;
    cause_d.ip = hwint;
    if (req) begin
      sr_d.exl        = 1'b1;
      cause_d.bd      = bd_m;
      cause_d.exccode = int_pend_s ? EXC_INT : exccode_m;
      epc_d           = bd_m ? (pc_m - 32'd4) : pc_m;
    end else begin
      if (cp0_we) begin
        case (cp0_addr)
          CP0_SR: begin
            sr_d.im  = cp0_wdata[SR_IM_LSB +: 6];
            sr_d.exl = cp0_wdata[SR_EXL_BIT];
            sr_d.ie  = cp0_wdata[SR_IE_BIT];
          end
          CP0_EPC: epc_d = cp0_wdata;
          default: epc_d = epc_q;
        endcase
      end else begin
        epc_d = epc_q;
      end
      if (eret_m) begin
        sr_d.exl = 1'b0;
      end else begin
        sr_d.exl = sr_d.exl;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q    <= SR_RESET;
      cause_q <= CAUSE_RESET;
      epc_q   <= 32'd0;
    end else begin
      sr_q    <= sr_d;
      cause_q <= cause_d;
      epc_q   <= epc_d;
    end
  end

  // mfc0 read mux returns pre-edge register contents.
  always_comb begin
    case (cp0_addr)
      CP0_SR:    cp0_rdata = pack_sr(sr_q);
      CP0_CAUSE: cp0_rdata = pack_cause(cause_q);
      CP0_EPC:   cp0_rdata = epc_q;
      CP0_PRID:  cp0_rdata = PRID;
      default:   cp0_rdata = 32'd0;
    endcase
  end

  assign epc_out    = epc_q;
  assign handler_pc = HANDLER_PC;

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Self-checking bench for cp0_exc_unit: directed scenarios plus randomized
// traffic checked against an architectural model of SR/Cause/EPC.
module tb_cp0_exc_unit;

  logic        clk;
  logic        reset;
  logic [31:0] pc_m;
  logic        bd_m;
  logic [4:0]  exccode_m;
  logic [5:0]  hwint;
  logic [4:0]  cp0_addr;
  logic        cp0_we;
  logic [31:0] cp0_wdata;
  logic        eret_m;
  logic [31:0] cp0_rdata;
  logic [31:0] epc_out;
  logic        req;
  logic [31:0] handler_pc;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_sr, m_cause, m_epc;

  cp0_exc_unit dut (
    .clk(clk), .reset(reset), .pc_m(pc_m), .bd_m(bd_m), .exccode_m(exccode_m),
    .hwint(hwint), .cp0_addr(cp0_addr), .cp0_we(cp0_we), .cp0_wdata(cp0_wdata),
    .eret_m(eret_m), .cp0_rdata(cp0_rdata), .epc_out(epc_out), .req(req),
    .handler_pc(handler_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit model_int();
    logic [5:0] im;
    im = m_sr[15:10];
    return ((hwint & im) != 6'd0) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic bit model_req();
    return !reset && (model_int() || (exccode_m != 5'd0 && !m_sr[1]));
  endfunction

  function automatic logic [31:0] model_rdata(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return 32'h0000_4D50;
      default: return 32'd0;
    endcase
  endfunction

  // Advance one clock; the architectural model takes the same inputs at that edge.
  task automatic tick();
    bit          r, ip;
    logic [31:0] nsr, ncause, nepc;
    r  = model_req();
    ip = model_int();
    nsr = m_sr;
    nepc = m_epc;
    ncause = (m_cause & 32'h8000_007C) | ({26'd0, hwint} << 10);
    if (r) begin
      nsr    = m_sr | 32'h0000_0002;
      ncause = ({31'd0, bd_m} << 31) | ({26'd0, hwint} << 10)
             | ({27'd0, (ip ? 5'd0 : exccode_m)} << 2);
      nepc   = bd_m ? pc_m - 32'd4 : pc_m;
    end else begin
      if (cp0_we && cp0_addr == 5'd12) nsr = cp0_wdata & 32'h0000_FC03;
      if (cp0_we && cp0_addr == 5'd14) nepc = cp0_wdata;
      if (eret_m) nsr = nsr & ~32'h0000_0002;
    end
    if (reset) begin
      nsr = 32'd0; ncause = 32'd0; nepc = 32'd0;
    end
    @(posedge clk);
    m_sr = nsr; m_cause = ncause; m_epc = nepc;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bd_m = 1'b0; exccode_m = 5'd0; cp0_we = 1'b0; cp0_wdata = 32'd0;
    eret_m = 1'b0; cp0_addr = 5'd0;
  endtask

  task automatic test_reset();
    logic [31:0] exp_r [4];
    exp_r[0] = 32'd0; exp_r[1] = 32'd0; exp_r[2] = 32'd0; exp_r[3] = 32'h0000_4D50;
    idle_inputs();
    pc_m = 32'd0; hwint = 6'h3F; reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cp0_addr = 5'(12 + i);
      #1;
      total++;
      if (cp0_rdata !== exp_r[i]) begin
        bad++; $display("FAIL reset_rdata addr=%0d got=%h want=%h", 12 + i, cp0_rdata, exp_r[i]);
      end
    end
    total++;
    if (req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", req); end
    total++;
    if (epc_out !== 32'd0) begin bad++; $display("FAIL reset_epc got=%h want=0", epc_out); end
    total++;
    if (handler_pc !== 32'h0000_4180) begin
      bad++; $display("FAIL handler_pc got=%h want=00004180", handler_pc);
    end
    tick();
  endtask

  task automatic test_interrupt();
    hwint = 6'd0;
    cp0_we = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_FC01;
    tick();
    cp0_we = 1'b0;
    #1;
    total++;
    if (cp0_rdata !== 32'h0000_FC01) begin bad++; $display("FAIL int_sr got=%h want=0000fc01", cp0_rdata); end
    hwint = 6'b000001; pc_m = 32'h0000_2000;
    #1;
    total++;
    if (req !== 1'b1) begin bad++; $display("FAIL int_req got=%b want=1", req); end
    tick();
    cp0_addr = 5'd13;
    #1;
    total++;
    if (cp0_rdata !== 32'h0000_0400) begin bad++; $display("FAIL int_cause got=%h want=00000400", cp0_rdata); end
    cp0_addr = 5'd12;
    #1;
    total++;
    if (cp0_rdata !== 32'h0000_FC03) begin bad++; $display("FAIL int_exl got=%h want=0000fc03", cp0_rdata); end
    total++;
    if (epc_out !== 32'h0000_2000) begin bad++; $display("FAIL int_epc got=%h want=00002000", epc_out); end
  endtask

  task automatic test_exception_bd();
    hwint = 6'd0; eret_m = 1'b1;
    tick();
    eret_m = 1'b0;
    exccode_m = 5'd4; bd_m = 1'b1; pc_m = 32'h0000_3008;
    #1;
    total++;
    if (req !== 1'b1) begin bad++; $display("FAIL adel_req got=%b want=1", req); end
    tick();
    exccode_m = 5'd0; bd_m = 1'b0;
    cp0_addr = 5'd13;
    #1;
    total++;
    if (cp0_rdata !== 32'h8000_0010) begin bad++; $display("FAIL adel_cause got=%h want=80000010", cp0_rdata); end
    total++;
    if (epc_out !== 32'h0000_3004) begin bad++; $display("FAIL adel_epc got=%h want=00003004", epc_out); end
  endtask

  task automatic test_exl_mask_eret();
    exccode_m = 5'd12; hwint = 6'b000001;
    #1;
    total++;
    if (req !== 1'b0) begin bad++; $display("FAIL exl_mask_req got=%b want=0", req); end
    tick();
    exccode_m = 5'd0;
    cp0_addr = 5'd13;
    #1;
    total++;
    if (cp0_rdata !== 32'h8000_0410) begin bad++; $display("FAIL exl_mask_cause got=%h want=80000410", cp0_rdata); end
    total++;
    if (epc_out !== 32'h0000_3004) begin bad++; $display("FAIL exl_mask_epc got=%h want=00003004", epc_out); end
    eret_m = 1'b1;
    #1;
    total++;
    if (req !== 1'b0) begin bad++; $display("FAIL eret_req got=%b want=0", req); end
    tick();
    eret_m = 1'b0; cp0_addr = 5'd12;
    #1;
    total++;
    if (cp0_rdata !== 32'h0000_FC01) begin bad++; $display("FAIL eret_sr got=%h want=0000fc01", cp0_rdata); end
    total++;
    if (req !== 1'b1) begin bad++; $display("FAIL eret_reraise got=%b want=1", req); end
    tick();
  endtask

  task automatic test_mtc0_suppressed();
    hwint = 6'd0; eret_m = 1'b1;
    tick();
    eret_m = 1'b0;
    exccode_m = 5'd10; pc_m = 32'h0000_4000;
    cp0_we = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'h0000_1234;
    #1;
    total++;
    if (req !== 1'b1) begin bad++; $display("FAIL ri_req got=%b want=1", req); end
    tick();
    cp0_we = 1'b0; exccode_m = 5'd0; cp0_addr = 5'd13;
    #1;
    total++;
    if (epc_out !== 32'h0000_4000) begin bad++; $display("FAIL ri_epc got=%h want=00004000", epc_out); end
    total++;
    if (cp0_rdata !== 32'h0000_0028) begin bad++; $display("FAIL ri_cause got=%h want=00000028", cp0_rdata); end
  endtask

  task automatic test_reset_mid_handler();
    hwint = 6'h3F; exccode_m = 5'd12; reset = 1'b1;
    #1;
    total++;
    if (req !== 1'b0) begin bad++; $display("FAIL rst_exl_req got=%b want=0", req); end
    tick();
    exccode_m = 5'd4;
    #1;
    total++;
    if (req !== 1'b0) begin bad++; $display("FAIL rst_forced_req got=%b want=0", req); end
    for (int i = 0; i < 3; i++) begin
      cp0_addr = 5'(12 + i);
      #1;
      total++;
      if (cp0_rdata !== 32'd0) begin bad++; $display("FAIL rst_mid addr=%0d got=%h want=0", 12 + i, cp0_rdata); end
    end
    tick();
    reset = 1'b0; exccode_m = 5'd0;
    tick();
  endtask

  task automatic test_random();
    logic [4:0] codes [4];
    codes[0] = 5'd4; codes[1] = 5'd5; codes[2] = 5'd10; codes[3] = 5'd12;
    for (int n = 0; n < 600; n++) begin
      reset     = ($urandom_range(49, 0) == 0);
      pc_m      = $urandom;
      bd_m      = 1'($urandom_range(1, 0));
      exccode_m = ($urandom_range(5, 0) == 0) ? codes[$urandom_range(3, 0)] : 5'd0;
      hwint     = ($urandom_range(3, 0) == 0) ? 6'($urandom) : 6'd0;
      cp0_we    = ($urandom_range(3, 0) == 0);
      cp0_addr  = 5'($urandom_range(17, 10));
      cp0_wdata = $urandom;
      eret_m    = !cp0_we && ($urandom_range(7, 0) == 0);
      #1;
      total++;
      if (req !== model_req()) begin bad++; $display("FAIL rnd_req n=%0d got=%b want=%b", n, req, model_req()); end
      total++;
      if (cp0_rdata !== model_rdata(cp0_addr)) begin
        bad++; $display("FAIL rnd_rdata n=%0d addr=%0d got=%h want=%h", n, cp0_addr, cp0_rdata, model_rdata(cp0_addr));
      end
      total++;
      if (epc_out !== m_epc) begin bad++; $display("FAIL rnd_epc n=%0d got=%h want=%h", n, epc_out, m_epc); end
      tick();
    end
  endtask

  initial begin
    m_sr = 32'd0; m_cause = 32'd0; m_epc = 32'd0;
    reset = 1'b1; hwint = 6'd0; pc_m = 32'd0;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_interrupt();
    test_exception_bd();
    test_exl_mask_eret();
    test_mtc0_suppressed();
    test_reset_mid_handler();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
